// File: rtl/ai_i2s_rx_frame_ctrl_if.sv
// ai_i2s_rx_frame_ctrl_if
// Stereo pair output bus from the I2S receive frame controller to the RX sample FIFO.
//   left_data / right_data : right-justified sample pair. Bits at or above num_bits are zero.
//   pair_valid             : a pair is presented.
//   pair_ready             : the consumer takes the pair.
// Handshake: a pair transfers on every clock edge where pair_valid and pair_ready are both high.
// While pair_valid is high and pair_ready is low, the producer holds the data stable.
// pair_valid never depends combinationally on pair_ready.
interface ai_i2s_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  pair_valid;
  logic                  pair_ready;

  modport master (
    output left_data,
    output right_data,
    output pair_valid,
    input  pair_ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  pair_valid,
    output pair_ready
  );
endinterface

// File: rtl/ai_i2s_rx_frame_ctrl.sv
// ai_i2s_rx_frame_ctrl
// Sequences one external bit deserializer for the I2S receive path. The block:
//   - aligns to WS with the I2S one-bit delay,
//   - gates serial bits into the deserializer slot by slot,
//   - pairs left and right words,
//   - presents stereo samples on pair_if.
// Ports:
//   clk, rst            : system clock; synchronous active-high reset.
//   enable              : receiver enable. When low, the block returns to IDLE.
//   cfg_num_bits        : sample width. It is latched when leaving IDLE.
//                         A value of 0 or a value above DATA_WIDTH selects DATA_WIDTH.
//   sck_rise_en         : one strobe per serial bit.
//   ws_in, sd_in        : synchronized WS and data, sampled on the strobe.
//   deser_*             : control of the deserializer, plus its word and word-valid returns.
//   pair_if             : stereo pair output, valid/ready.
//   overflow, frame_err : sticky flags, cleared by clear_err.
//   dbg_state           : current FSM state (0 IDLE, 1 WAIT_SYNC, 2 LEFT, 3 RIGHT).
module ai_i2s_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [5:0]            cfg_num_bits,
  input  logic                  sck_rise_en,
  input  logic                  ws_in,
  input  logic                  sd_in,
  output logic                  deser_enable,
  output logic                  deser_clk_en,
  output logic                  deser_bit,
  output logic [5:0]            deser_num_bits,
  input  logic [DATA_WIDTH-1:0] deser_data,
  input  logic                  deser_valid,
  ai_i2s_rx_frame_ctrl_if.master pair_if,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clear_err,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_LEFT      = 2'd2,
    ST_RIGHT     = 2'd3
  } state_t;

  localparam logic [5:0] MAX_BITS = 6'(DATA_WIDTH);
  // The slot bit counter saturates. Any slot longer than 64 bits is already complete.
  localparam logic [6:0] IDX_SAT  = 7'd64;

  state_t                state_q, state_d;
  logic [5:0]            num_bits_q, num_bits_d;
  logic [6:0]            bit_idx_q, bit_idx_d;
  logic                  ws_prev_q, ws_prev_d;
  logic                  ws_init_q, ws_init_d;
  logic                  tag_right_q, tag_right_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_hold_valid_q, left_hold_valid_d;
  logic [DATA_WIDTH-1:0] left_data_q, left_data_d;
  logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
  logic                  pair_valid_q, pair_valid_d;
  logic                  deser_enable_q, deser_enable_d;
  logic                  deser_clk_en_q, deser_clk_en_d;
  logic                  deser_bit_q, deser_bit_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;

  logic [5:0]            cfg_eff;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] word_masked;
  logic [6:0]            nb_ext;
  logic                  slot_end;
  logic                  short_slot;
  logic                  ovf_set;
  logic                  ferr_set;

  always_comb begin
    cfg_eff = cfg_num_bits;
    if (cfg_num_bits == 6'd0 || cfg_num_bits > MAX_BITS) cfg_eff = MAX_BITS;
    mask = '1;
    if (num_bits_q < MAX_BITS) mask = (DATA_WIDTH'(1) << num_bits_q) - DATA_WIDTH'(1);
    word_masked = deser_data & mask;
    nb_ext      = {1'b0, num_bits_q};
    // A WS change marks the last bit of the current slot, not the first bit of the next one.
    slot_end    = (ws_in != ws_prev_q);
    short_slot  = slot_end && ((bit_idx_q + 7'd1) < nb_ext);
  end

  always_comb begin
    state_d           = state_q;
    num_bits_d        = num_bits_q;
    bit_idx_d         = bit_idx_q;
    ws_prev_d         = ws_prev_q;
    ws_init_d         = ws_init_q;
    tag_right_d       = tag_right_q;
    left_hold_d       = left_hold_q;
    left_hold_valid_d = left_hold_valid_q;
    left_data_d       = left_data_q;
    right_data_d      = right_data_q;
    pair_valid_d      = pair_valid_q;
    deser_enable_d    = 1'b0;
    deser_clk_en_d    = 1'b0;
    deser_bit_d       = 1'b0;
    ovf_set           = 1'b0;
    ferr_set          = 1'b0;

    if (!enable) begin
      state_d           = ST_IDLE;
      bit_idx_d         = '0;
      ws_init_d         = 1'b0;
      tag_right_d       = 1'b0;
      left_hold_d       = '0;
      left_hold_valid_d = 1'b0;
      left_data_d       = '0;
      right_data_d      = '0;
      pair_valid_d      = 1'b0;
    end else begin
      deser_enable_d = 1'b1;
      if (pair_valid_q && pair_if.pair_ready) pair_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          num_bits_d = cfg_eff;
          bit_idx_d  = '0;
          ws_init_d  = 1'b0;
          state_d    = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (sck_rise_en) begin
            ws_prev_d = ws_in;
            ws_init_d = 1'b1;
            // The first strobe only seeds ws_prev, so a stale reset value cannot fake an edge.
            if (ws_init_q && ws_prev_q && !ws_in) begin
              state_d   = ST_LEFT;
              bit_idx_d = '0;
            end
          end
        end
        default: begin
          if (deser_valid) begin
            if (!tag_right_q) begin
              left_hold_d       = word_masked;
              left_hold_valid_d = 1'b1;
            end else if (left_hold_valid_q) begin
              left_hold_valid_d = 1'b0;
              if (!pair_valid_q || pair_if.pair_ready) begin
                left_data_d  = left_hold_q;
                right_data_d = word_masked;
                pair_valid_d = 1'b1;
              end else begin
                ovf_set = 1'b1;
              end
            end
          end
          if (sck_rise_en) begin
            ws_prev_d = ws_in;
            if (short_slot) begin
              // A one-cycle enable drop replaces this bit's shift and clears the partial count.
              ferr_set       = 1'b1;
              deser_enable_d = 1'b0;
              if (state_q == ST_LEFT) left_hold_valid_d = 1'b0;
            end else if (bit_idx_q < nb_ext) begin
              deser_clk_en_d = 1'b1;
              deser_bit_d    = sd_in;
              if (bit_idx_q == nb_ext - 7'd1) tag_right_d = (state_q == ST_RIGHT);
            end
            if (slot_end) begin
              bit_idx_d = '0;
              state_d   = (state_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
            end else if (bit_idx_q != IDX_SAT) begin
              bit_idx_d = bit_idx_q + 7'd1;
            end
          end
        end
      endcase
    end

    // When a set event and clear_err occur in the same cycle, the set wins.
    overflow_d  = (overflow_q & ~clear_err) | ovf_set;
    frame_err_d = (frame_err_q & ~clear_err) | ferr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      num_bits_q        <= MAX_BITS;
      bit_idx_q         <= '0;
      ws_prev_q         <= 1'b0;
      ws_init_q         <= 1'b0;
      tag_right_q       <= 1'b0;
      left_hold_q       <= '0;
      left_hold_valid_q <= 1'b0;
      left_data_q       <= '0;
      right_data_q      <= '0;
      pair_valid_q      <= 1'b0;
      deser_enable_q    <= 1'b0;
      deser_clk_en_q    <= 1'b0;
      deser_bit_q       <= 1'b0;
      overflow_q        <= 1'b0;
      frame_err_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      num_bits_q        <= num_bits_d;
      bit_idx_q         <= bit_idx_d;
      ws_prev_q         <= ws_prev_d;
      ws_init_q         <= ws_init_d;
      tag_right_q       <= tag_right_d;
      left_hold_q       <= left_hold_d;
      left_hold_valid_q <= left_hold_valid_d;
      left_data_q       <= left_data_d;
      right_data_q      <= right_data_d;
      pair_valid_q      <= pair_valid_d;
      deser_enable_q    <= deser_enable_d;
      deser_clk_en_q    <= deser_clk_en_d;
      deser_bit_q       <= deser_bit_d;
      overflow_q        <= overflow_d;
      frame_err_q       <= frame_err_d;
    end
  end

  assign deser_enable       = deser_enable_q;
  assign deser_clk_en       = deser_clk_en_q;
  assign deser_bit          = deser_bit_q;
  assign deser_num_bits     = num_bits_q;
  assign pair_if.left_data  = left_data_q;
  assign pair_if.right_data = right_data_q;
  assign pair_if.pair_valid = pair_valid_q;
  assign overflow           = overflow_q;
  assign frame_err          = frame_err_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_ai_i2s_rx_frame_ctrl.sv
module tb_ai_i2s_rx_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [5:0]  cfg_num_bits;
  logic        sck_rise_en, ws_in, sd_in;
  logic        deser_enable, deser_clk_en, deser_bit;
  logic [5:0]  deser_num_bits;
  logic [31:0] deser_data;
  logic        deser_valid;
  logic        overflow, frame_err, clear_err;
  logic [1:0]  dbg_state;

  ai_i2s_rx_frame_ctrl_if #(.DATA_WIDTH(32)) pair_if ();

  ai_i2s_rx_frame_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_num_bits(cfg_num_bits),
    .sck_rise_en(sck_rise_en), .ws_in(ws_in), .sd_in(sd_in),
    .deser_enable(deser_enable), .deser_clk_en(deser_clk_en), .deser_bit(deser_bit),
    .deser_num_bits(deser_num_bits), .deser_data(deser_data), .deser_valid(deser_valid),
    .pair_if(pair_if), .overflow(overflow), .frame_err(frame_err),
    .clear_err(clear_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int gap = 1;
  int pv_rise_cyc = -1;
  logic pv_seen = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Deserializer stand-in: MSB-first shifter. Its upper bits keep stale data, so the masking must clear them.
  logic [31:0] ds_sh;
  int          ds_cnt;
  always @(posedge clk) begin
    if (rst) begin
      ds_sh <= '1; ds_cnt <= 0; deser_valid <= 1'b0; deser_data <= '0;
    end else if (!deser_enable) begin
      ds_cnt <= 0; deser_valid <= 1'b0;
    end else begin
      deser_valid <= 1'b0;
      if (deser_clk_en) begin
        ds_sh <= {ds_sh[30:0], deser_bit};
        if (ds_cnt + 1 == int'(deser_num_bits)) begin
          ds_cnt <= 0; deser_valid <= 1'b1; deser_data <= {ds_sh[30:0], deser_bit};
        end else begin
          ds_cnt <= ds_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each transferred pair is matched against the next expected pair.
  always @(negedge clk) begin
    if (!rst) begin
      if (pair_if.pair_valid && !pv_seen) pv_rise_cyc = cyc;
      pv_seen = pair_if.pair_valid;
      if (pair_if.pair_valid && pair_if.pair_ready) begin
        chk("pair_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("pair_left", 64'(pair_if.left_data), 64'(e[63:32]));
          chk("pair_right", 64'(pair_if.right_data), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic ws, input logic sd, output int scyc,
                          output logic den_t1, output logic cen_t1);
    sck_rise_en = 1'b1; ws_in = ws; sd_in = sd; scyc = cyc;
    @(posedge clk); #1;
    sck_rise_en = 1'b0;
    den_t1 = deser_enable; cen_t1 = deser_clk_en;
    tick(gap);
  endtask

  task automatic send_slot(input logic ch, input int len, input logic [31:0] raw, input int nb,
                           output int t_last, output logic den_end);
    logic [31:0] sh;
    int sc;
    logic den, cen;
    sh = raw; t_last = -1; den_end = 1'b1;
    for (int i = 0; i < len; i++) begin
      send_bit((i == len - 1) ? ~ch : ch, sh[31], sc, den, cen);
      sh = sh << 1;
      if (i == nb - 1) t_last = sc;
      if (i == len - 1) den_end = den;
    end
  endtask

  task automatic send_frame(input logic [31:0] l_raw, input logic [31:0] r_raw,
                            input int len_l, input int len_r, input int nb, output int t_last_r);
    int tl;
    logic de;
    send_slot(1'b0, len_l, l_raw, nb, tl, de);
    send_slot(1'b1, len_r, r_raw, nb, t_last_r, de);
  endtask

  // Re-enable with a new width, then sync. The preamble starts mid-left slot, passes a
  // 0->1 edge (which must not sync), and ends on the 1->0 edge that does.
  task automatic restart(input logic [5:0] cfg, input int exp_nb);
    logic [4:0] pre_ws;
    int sc, cen_cnt;
    logic den, cen;
    enable = 1'b0; tick(3);
    cfg_num_bits = cfg; enable = 1'b1; tick(2);
    chk("latched_num_bits", 64'(deser_num_bits), 64'(exp_nb));
    pre_ws = 5'b00110; cen_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      send_bit(pre_ws[4], 1'($urandom_range(0, 1)), sc, den, cen);
      pre_ws = pre_ws << 1;
      if (cen) cen_cnt++;
    end
    chk("sync_no_forward", 64'(cen_cnt), 64'd0);
    chk("sync_state_left", 64'(dbg_state), 64'd2);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          cfg;
    int          exp_nb;
    int          len_l;
    int          len_r;
    logic [31:0] l_raw;
    logic [31:0] r_raw;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vec[8];

  initial begin
    int t_last, tl, sc, cur_cfg;
    logic de, cen;
    int nb, len, hold_v;
    logic [31:0] raw, word, hold;
    logic ferr_m;

    vec[0] = '{16, 16, 32, 32, 32'hA5C3_6B9E, 32'h1234_F0F0, 32'h0000_A5C3, 32'h0000_1234};
    vec[1] = '{24, 24, 24, 24, 32'h8000_0100, 32'h7FFF_FE00, 32'h0080_0001, 32'h007F_FFFE};
    vec[2] = '{24, 24, 24, 24, 32'h8000_0200, 32'h7FFF_FD00, 32'h0080_0002, 32'h007F_FFFD};
    vec[3] = '{24, 24, 24, 24, 32'h8000_0300, 32'h7FFF_FC00, 32'h0080_0003, 32'h007F_FFFC};
    vec[4] = '{24, 24, 24, 24, 32'h8000_0400, 32'h7FFF_FB00, 32'h0080_0004, 32'h007F_FFFB};
    vec[5] = '{ 0, 32, 32, 32, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    vec[6] = '{40, 32, 32, 32, 32'h1234_5678, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321};
    vec[7] = '{ 8,  8, 12, 10, 32'hC3F0_0000, 32'h5A40_0000, 32'h0000_00C3, 32'h0000_005A};

    rst = 1'b1; enable = 1'b0; cfg_num_bits = 6'd0; sck_rise_en = 1'b0; ws_in = 1'b0;
    sd_in = 1'b0; clear_err = 1'b0; pair_if.pair_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_deser_enable", 64'(deser_enable), 64'd0);
    chk("rst_deser_clk_en", 64'(deser_clk_en), 64'd0);
    chk("rst_deser_bit", 64'(deser_bit), 64'd0);
    chk("rst_num_bits", 64'(deser_num_bits), 64'd32);
    chk("rst_left", 64'(pair_if.left_data), 64'd0);
    chk("rst_right", 64'(pair_if.right_data), 64'd0);
    chk("rst_pair_valid", 64'(pair_if.pair_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // Table vectors: one full frame each.
    cur_cfg = -1;
    for (int i = 0; i < 8; i++) begin
      if (vec[i].cfg != cur_cfg) begin
        restart(6'(vec[i].cfg), vec[i].exp_nb);
        cur_cfg = vec[i].cfg;
      end
      exp_q.push_back({vec[i].exp_l, vec[i].exp_r});
      send_frame(vec[i].l_raw, vec[i].r_raw, vec[i].len_l, vec[i].len_r, vec[i].exp_nb, t_last);
      tick(6);
      if (i == 0) chk("pair_valid_latency", 64'(pv_rise_cyc - t_last), 64'd3);
      chk("vec_drained", 64'(exp_q.size()), 64'd0);
    end

    // Backpressure: the first pair is held, the second is dropped, and overflow is set.
    restart(6'd16, 16);
    pair_if.pair_ready = 1'b0;
    exp_q.push_back({32'h0000_BEEF, 32'h0000_CAFE});
    send_frame(32'hBEEF_0000, 32'hCAFE_0000, 16, 16, 16, t_last);
    send_frame(32'h1111_0000, 32'h2222_0000, 16, 16, 16, t_last);
    tick(6);
    chk("ovf_pair_valid", 64'(pair_if.pair_valid), 64'd1);
    chk("ovf_left_held", 64'(pair_if.left_data), 64'h0000_BEEF);
    chk("ovf_right_held", 64'(pair_if.right_data), 64'h0000_CAFE);
    chk("ovf_flag", 64'(overflow), 64'd1);
    pair_if.pair_ready = 1'b1;
    tick(2);
    chk("ovf_pair_taken", 64'(pair_if.pair_valid), 64'd0);
    chk("ovf_drained", 64'(exp_q.size()), 64'd0);
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Short left slot: flush for one cycle, the orphan right word is dropped, then the next frame pairs.
    restart(6'd32, 32);
    send_slot(1'b0, 20, 32'hFFFF_F000, 32, tl, de);
    chk("flush_deser_enable_low", 64'(de), 64'd0);
    chk("flush_one_cycle", 64'(deser_enable), 64'd1);
    chk("short_frame_err", 64'(frame_err), 64'd1);
    send_slot(1'b1, 32, 32'h5555_AAAA, 32, tl, de);
    exp_q.push_back({32'h0F0F_3C3C, 32'hC001_D00D});
    send_frame(32'h0F0F_3C3C, 32'hC001_D00D, 32, 32, 32, t_last);
    tick(6);
    chk("short_drained", 64'(exp_q.size()), 64'd0);

    // Enable dropped mid-left slot: outputs are cleared and sticky flags are kept.
    for (int k = 0; k < 5; k++) send_bit(1'b0, 1'b1, sc, de, cen);
    enable = 1'b0;
    tick(2);
    chk("drop_state_idle", 64'(dbg_state), 64'd0);
    chk("drop_deser_enable", 64'(deser_enable), 64'd0);
    chk("drop_pair_valid", 64'(pair_if.pair_valid), 64'd0);
    chk("drop_left_zero", 64'(pair_if.left_data), 64'd0);
    chk("drop_right_zero", 64'(pair_if.right_data), 64'd0);
    chk("drop_frame_err_kept", 64'(frame_err), 64'd1);
    restart(6'd8, 8);
    exp_q.push_back({32'h0000_0081, 32'h0000_007E});
    send_frame(32'h81FF_FFFF, 32'h7E00_0000, 8, 8, 8, t_last);
    exp_q.push_back({32'h0000_00FF, 32'h0000_0001});
    send_frame(32'hFF00_0000, 32'h01FF_FFFF, 8, 8, 8, t_last);
    tick(6);
    chk("resync_drained", 64'(exp_q.size()), 64'd0);
    chk("resync_frame_err_kept", 64'(frame_err), 64'd1);

    // Random frames against the frame-level reference model.
    for (int r = 0; r < 5; r++) begin
      nb = $urandom_range(4, 32);
      gap = $urandom_range(1, 3);
      restart(6'(nb), nb);
      clear_err = 1'b1; tick(1); clear_err = 1'b0;
      ferr_m = 1'b0; hold_v = 0; hold = '0;
      for (int f = 0; f < 6; f++) begin
        for (int ch = 0; ch < 2; ch++) begin
          len = $urandom_range((nb - 3 < 2) ? 2 : nb - 3, nb + 4);
          raw = $urandom;
          word = raw >> (32 - nb);
          if (len < nb) begin
            ferr_m = 1'b1;
            if (ch == 0) hold_v = 0;
          end else if (ch == 0) begin
            hold = word; hold_v = 1;
          end else if (hold_v != 0) begin
            exp_q.push_back({hold, word});
            hold_v = 0;
          end
          send_slot(1'(ch), len, raw, nb, tl, de);
        end
      end
      tick(8);
      chk("rand_frame_err", 64'(frame_err), 64'(ferr_m));
      chk("rand_overflow", 64'(overflow), 64'd0);
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ai_i2s_rx_frame_ctrl.md
# ai_i2s_rx_frame_ctrl

I2S receive frame controller that sequences one `ai_i2s_bit_deserializer` instance for the receive path. It tracks the synchronized word-select (WS) line and aligns to I2S framing, with a one-bit delay after each WS edge. It gates serial bits into the deserializer per slot, masks and pairs left/right words, and presents stereo samples on a valid/ready interface. It sits between the SCK/WS/SD synchronizer and the RX sample FIFO.

## Interface
- `DATA_WIDTH`, default 32: maximum sample width; must match the deserializer.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  receiver enable; low forces IDLE.
- `cfg_num_bits`  in  6  sample width, latched on the cycle `enable` rises (IDLE only). Values 0 or >DATA_WIDTH are treated as DATA_WIDTH.
- `sck_rise_en`  in  1  one-cycle strobe per serial bit sample point; strobes are ≥2 clk apart.
- `ws_in`  in  1  synchronized WS; 0 = left, 1 = right. Sampled only on strobe.
- `sd_in`  in  1  synchronized serial data. Sampled only on strobe.
- `deser_enable`  out  1  deserializer enable.
- `deser_clk_en`  out  1  deserializer shift strobe.
- `deser_bit`  out  1  deserializer serial input.
- `deser_num_bits`  out  6  latched effective sample width.
- `deser_data`  in  DATA_WIDTH  deserializer word.
- `deser_valid`  in  1  deserializer word valid.
- `left_data`, `right_data`  out  DATA_WIDTH each  right-justified stereo pair; bits ≥ num_bits are zero.
- `pair_valid`  out  1  pair available.
- `pair_ready`  in  1  consumer accepts the pair.
- `overflow`  out  1  sticky: a completed pair was dropped.
- `frame_err`  out  1  sticky: a slot was shorter than num_bits.
- `clear_err`  in  1  clears both sticky flags.

## Operation
- States:
  - IDLE: `deser_enable`=0. On `enable`=1, latch num_bits and go to WAIT_SYNC.
  - WAIT_SYNC: `deser_enable`=1. Record `ws_prev` at each strobe. The first observed 1→0 WS transition enters LEFT. Data is never forwarded in WAIT_SYNC, and the first strobe only initializes `ws_prev`.
  - LEFT / RIGHT: per strobe, bit_idx counts from 0.
- Forwarding: a strobe with bit_idx < num_bits forwards `sd_in`. The strobe that forwards the bit at bit_idx = num_bits−1 tags the in-flight word with the current channel. Bits beyond num_bits are ignored.
- Slot end: a strobe where `ws_in` ≠ `ws_prev` still belongs to the current slot, because it carries the old word's LSB. After it is processed, bit_idx resets to 0 and the state toggles LEFT↔RIGHT. The next strobe is the new slot's MSB.
- Short slot: the slot ends with fewer than num_bits bits forwarded. Response:
  - set `frame_err`;
  - hold `deser_enable` low one cycle in place of a shift, which flushes the deserializer's partial count;
  - discard the partial word;
  - if the short slot was LEFT, also clear left_hold_valid.
- Pairing:
  - A `deser_valid` tagged left loads left_hold (masked) and sets left_hold_valid.
  - A `deser_valid` tagged right with left_hold_valid completes a pair.
  - A `deser_valid` tagged right without left_hold_valid is dropped silently.
- Output:
  - A completed pair loads `left_data`/`right_data` and sets `pair_valid` when `pair_valid`=0, or when `pair_ready`=1 in the same cycle.
  - Otherwise the new pair is dropped, the old pair is held, and `overflow` is set.
  - `pair_valid` clears on `pair_valid`&`pair_ready` when no new pair loads.
- Masking: each word is `deser_data & ((1<<num_bits)−1)`. With num_bits = DATA_WIDTH the mask is all ones.
- `enable` low in any state:
  - next cycle: IDLE, `deser_enable`=0, hold and output registers cleared, `pair_valid`=0;
  - sticky flags are retained.
- Sticky flags: `clear_err` clears them. A set event in the same cycle as `clear_err` wins.

## Timing
- Reset values: `deser_enable`/`deser_clk_en`/`deser_bit`=0, `deser_num_bits`=DATA_WIDTH, data outputs 0, `pair_valid`/`overflow`/`frame_err`=0, state IDLE.
- All outputs are registered.
- `deser_clk_en`/`deser_bit` are asserted the cycle after the strobe (T+1).
- Deserializer `deser_valid` appears at T+2.
- `left_data` hold register loads at T+3.
- `pair_valid` is asserted at T+3, where T is the strobe of the right word's last forwarded bit.
- The flush (`deser_enable`=0) occurs at T+1 of the slot-ending strobe.

## Test plan
- num_bits=16, 32-bit slots, L=0xA5C3, R=0x1234, `pair_ready`=1 → `left_data`=0x0000A5C3, `right_data`=0x00001234, `pair_valid` at T+3 of right bit 15; bits 16..31 are ignored.
- num_bits=24, 24-bit slots, four frames, L=0x800001+n, R=0x7FFFFE−n → four pairs in order, upper byte zero.
- Start mid-right-slot with WS=1 → no forwarding until the first 1→0 edge; the first pair is the first full L/R frame.
- `pair_ready`=0 for two frames → the first pair is held, the second is dropped, `overflow`=1; `clear_err` → `overflow`=0.
- num_bits=32 with a left slot truncated to 20 bits → `frame_err`=1, one-cycle `deser_enable` low, following right word dropped; the next full frame pairs correctly.
- `enable` dropped mid-left-slot, then re-enabled with num_bits=8 → IDLE, outputs cleared, sticky flags retained; 8-bit pairs decode after WS resync.
